axis_pattern_gen: RTL and testbench
===================================

// Module: axis_pattern_gen
// PURPOSE
//  Parametrised AXI-Stream test-pattern source; replaces fixed tie-off/stub masters in sim and bring-up tops.
//  Emits framed traffic (SOF on tuser, tlast), round-robin channel id, selectable data pattern, inter-frame gap.
//  Sits on the clock/rst_n domain from simple_clock; its output feeds any axi_stream_inf slave under test.
// PARAMETERS
//  DSIZE   16  tdata width in bits (>=1)
//  LEN_W   16  width of the frame-length, frame-count and gap fields
//  NUM_CH  1   channel count; out_tid width is CH_W = max(1,$clog2(NUM_CH))
// PORTS
//  clock         in   1      single clock
//  rst_n         in   1      asynchronous reset, active low
//  start         in   1      1-cycle pulse; latches all cfg_* inputs; honoured only in IDLE
//  stop          in   1      1-cycle pulse; request graceful end after the current frame
//  cfg_mode      in   2      0 COUNT, 1 PRBS15, 2 CONST, 3 WALK1
//  cfg_seed      in   DSIZE  initial data value (COUNT/CONST), LFSR seed bits [14:0] (PRBS15)
//  cfg_frame_len in   LEN_W  beats per frame; 0 is treated as 1
//  cfg_frame_num in   LEN_W  frames to send; 0 = run until stop
//  cfg_gap       in   LEN_W  idle cycles between frames (tvalid low)
//  out_tdata     out  DSIZE  stream data
//  out_tvalid    out  1      stream valid
//  out_tready    in   1      stream ready
//  out_tlast     out  1      last beat of frame
//  out_tuser     out  1      SOF: high on the first beat of each frame
//  out_tid       out  CH_W   channel = frame index mod NUM_CH
//  busy          out  1      high from the cycle after an accepted start until DONE
//  done          out  1      1-cycle pulse when a run ends
//  frame_cnt     out  LEN_W  frames fully accepted in the current/last run (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, data registers 0; async assert, sync release.
//  FSM IDLE->SEND on start (1-cycle latency: out_tvalid high the cycle after start).
//  SEND->GAP on accepted tlast beat if frames remain and cfg_gap!=0; SEND->SEND if cfg_gap==0.
//  SEND->DONE on accepted tlast beat when frame_cnt+1==frame_num or a stop is pending.
//  GAP holds for exactly cfg_gap cycles, then SEND; a stop seen in GAP goes directly to DONE.
//  DONE: one cycle, done=1, busy=0, then IDLE.
//  Handshake: beat accepted iff out_tvalid&out_tready; once valid, tdata/tlast/tuser/tid stay stable until accepted.
//  Valid is never withdrawn without acceptance; tready low for any duration stalls pattern and counters.
//  stop is sticky until DONE; it never truncates a frame. stop in IDLE is ignored.
//  start while busy is ignored; cfg_* changes mid-run have no effect.
//  Patterns advance once per accepted beat and continue across frames; restart from seed on each start:
//   COUNT: seed, seed+1, ... mod 2^DSIZE.  CONST: seed on every beat.
//   PRBS15: x^15+x^14+1 Fibonacci LFSR; state 0 is replaced by 15'h0001; tdata = LFSR state replicated to DSIZE, LSB-aligned.
//   WALK1: 1,2,4,... rotate-left, wraps to bit 0 after bit DSIZE-1.
//  out_tid starts at 0, increments after each tlast, wraps NUM_CH-1 -> 0.
//  Beat counter compares against frame_len-1; frame_len of 1 gives tlast=tuser=1 on the same beat.
//  frame_num==0: infinite; frame_cnt wraps at 2^LEN_W without ending the run.
//  Reset mid-frame: tvalid drops asynchronously; no done pulse is generated.
// STRUCTURE
//  Package axis_pattern_pkg: typedef enum pat_mode_e {COUNT,PRBS15,CONST,WALK1}; typedef enum gen_state_e
//   {IDLE,SEND,GAP,DONE}; localparam PRBS_POLY, PRBS_NONZERO_SEED = 15'h0001.
//  Sub-module axis_pattern_src: mode, seed, load, advance -> DSIZE data register.
//  Top level holds the FSM, beat/gap/frame counters, and the tid counter.
// TESTING
//  COUNT, seed 0, len 4, num 2, gap 3, tready=1 -> tdata 0..7; tlast on 3 and 7; tuser on 0 and 4; 3 idle cycles between frames; done one cycle after beat 7.
//  Same config, tready toggled 1010... -> identical beat sequence; tdata stable whenever valid&!ready; done delayed accordingly.
//  PRBS15, seed 0, DSIZE 16, len 8, num 1 -> first beat 16'h0001, successive beats follow the LFSR reference model, 1 tlast.
//  WALK1, DSIZE 4, NUM_CH 3, len 5, num 4, gap 0 -> data 1,2,4,8,1,...; tid 0,1,2,0; back-to-back frames with no bubble.
//  num 0, stop pulsed on beat 2 of frame 1 with len 6 -> frame 1 completes (tlast on beat 5), then DONE, frame_cnt=2.
//  rst_n low mid-frame then release, then start -> tvalid 0 during reset; new run restarts from seed with tid 0.

Source files
------------

// File: rtl/axis_pattern_gen_pkg.sv
// Shared types and constants for the AXI-Stream pattern generator.
package axis_pattern_pkg;

   typedef enum logic [1:0] {
      COUNT  = 2'd0,
      PRBS15 = 2'd1,
      CONST  = 2'd2,
      WALK1  = 2'd3
   } pat_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } gen_state_e;

   // Taps for x^15 + x^14 + 1 (state bits 14 and 13).
   localparam logic [14:0] PRBS_POLY         = 15'h6000;
   // An all-zero LFSR locks up, so a zero seed is replaced by this value.
   localparam logic [14:0] PRBS_NONZERO_SEED = 15'h0001;

   // One Fibonacci step: shift left, feedback into bit 0.
   function automatic logic [14:0] prbs15_next(input logic [14:0] s);
      return {s[13:0], ^(s & PRBS_POLY)};
   endfunction

endpackage

// File: rtl/axis_pattern_gen_if.sv
// AXI-Stream bundle driven by the pattern generator.
interface axis_pattern_gen_if #(
   parameter int DSIZE = 16,
   parameter int CH_W  = 1
);
   logic [DSIZE-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic             tuser;
   logic [CH_W-1:0]  tid;

   modport master (output tdata, tvalid, tlast, tuser, tid, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, tid, output tready);
endinterface

// File: rtl/axis_pattern_gen_src.sv
// Data-pattern register: loaded from seed at run start, advanced once per accepted beat.
module axis_pattern_src
   import axis_pattern_pkg::*;
#(
   parameter int DSIZE = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  pat_mode_e        mode,
   input  logic [DSIZE-1:0] seed,
   input  logic             load,
   input  logic             advance,
   output logic [DSIZE-1:0] data
);

   // Whole 15-bit copies of the LFSR fill tdata from bit 0; bits above the
   // last whole copy stay zero. Narrow buses (<15) take the truncated state.
   localparam int SPREAD_W = (DSIZE < 15) ? DSIZE : 15 * (DSIZE / 15);

   function automatic logic [DSIZE-1:0] spread(input logic [14:0] s);
      logic [DSIZE-1:0] r;
      r = '0;
      for (int i = 0; i < DSIZE; i++)
         if (i < SPREAD_W) r[i] = s[i % 15];
      return r;
   endfunction

   pat_mode_e        mode_q;
   logic [14:0]      lfsr_q;
   logic [DSIZE-1:0] data_q;
   logic [14:0]      seed15;
   logic [14:0]      lfsr_seed;
   logic [14:0]      lfsr_nxt;

   generate
      if (DSIZE >= 15) begin : g_seed_wide
         assign seed15 = seed[14:0];
      end else begin : g_seed_narrow
         assign seed15 = 15'(seed);
      end
   endgenerate

   assign lfsr_seed = (seed15 == '0) ? PRBS_NONZERO_SEED : seed15;
   assign lfsr_nxt  = prbs15_next(lfsr_q);
   assign data      = data_q;

   // Pattern state: seed on load, one step per accepted beat.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= COUNT;
         lfsr_q <= '0;
         data_q <= '0;
      end else if (load) begin
         mode_q <= mode;
         lfsr_q <= lfsr_seed;
         case (mode)
            PRBS15:  data_q <= spread(lfsr_seed);
            WALK1:   data_q <= DSIZE'(1);
            default: data_q <= seed;
         endcase
      end else if (advance) begin
         case (mode_q)
            COUNT:   data_q <= data_q + DSIZE'(1);
            PRBS15: begin
               lfsr_q <= lfsr_nxt;
               data_q <= spread(lfsr_nxt);
            end
            WALK1:   data_q <= (data_q << 1) | (data_q >> (DSIZE - 1));
            default: data_q <= data_q;
         endcase
      end
   end

endmodule

// File: rtl/axis_pattern_gen.sv
// Framed AXI-Stream test-pattern source with channel rotation and inter-frame gap.
module axis_pattern_gen
   import axis_pattern_pkg::*;
#(
   parameter int DSIZE  = 16,
   parameter int LEN_W  = 16,
   parameter int NUM_CH = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        cfg_mode,
   input  logic [DSIZE-1:0]  cfg_seed,
   input  logic [LEN_W-1:0]  cfg_frame_len,
   input  logic [LEN_W-1:0]  cfg_frame_num,
   input  logic [LEN_W-1:0]  cfg_gap,
   axis_pattern_gen_if.master out,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  frame_cnt
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   gen_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_m1_q, num_q, gap_cfg_q;
   logic [LEN_W-1:0] beat_q, gap_q, frame_cnt_q;
   logic [CH_W-1:0]  tid_q;
   logic             stop_q;
   logic [DSIZE-1:0] src_data;

   logic             launch, accept, beat_last, frame_end, stop_pend, run_over;
   logic [LEN_W-1:0] cnt_inc;

   assign launch    = (state_q == IDLE) && start;
   assign accept    = (state_q == SEND) && out.tready;
   assign beat_last = (beat_q == len_m1_q);
   assign frame_end = accept && beat_last;
   assign stop_pend = stop_q || stop;
   assign cnt_inc   = frame_cnt_q + LEN_W'(1);
   assign run_over  = stop_pend || ((num_q != '0) && (cnt_inc == num_q));

   axis_pattern_src #(.DSIZE(DSIZE)) u_src (
      .clock   (clock),
      .rst_n   (rst_n),
      .mode    (pat_mode_e'(cfg_mode)),
      .seed    (cfg_seed),
      .load    (launch),
      .advance (accept),
      .data    (src_data)
   );

   // State register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: frames end only on an accepted tlast; stop cuts a gap short.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SEND;
         SEND: begin
            if (frame_end) begin
               if (run_over)              state_d = DONE;
               else if (gap_cfg_q != '0)  state_d = GAP;
               else                       state_d = SEND;
            end
         end
         GAP: begin
            if (stop_pend)                 state_d = DONE;
            else if (gap_q == LEN_W'(1))   state_d = SEND;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: framing flags only meaningful while a beat is offered.
   always_comb begin
      out.tvalid = (state_q == SEND);
      out.tlast  = (state_q == SEND) && beat_last;
      out.tuser  = (state_q == SEND) && (beat_q == '0);
      out.tid    = tid_q;
      out.tdata  = src_data;
      busy       = (state_q == SEND) || (state_q == GAP);
      done       = (state_q == DONE);
      frame_cnt  = frame_cnt_q;
   end

   // Run configuration, captured once per start so mid-run cfg changes are inert.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         len_m1_q  <= '0;
         num_q     <= '0;
         gap_cfg_q <= '0;
      end else if (launch) begin
         len_m1_q  <= (cfg_frame_len == '0) ? '0 : cfg_frame_len - LEN_W'(1);
         num_q     <= cfg_frame_num;
         gap_cfg_q <= cfg_gap;
      end
   end

   // Beat, frame and channel counters; all frozen while tready is low.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         beat_q      <= '0;
         frame_cnt_q <= '0;
         tid_q       <= '0;
      end else if (launch) begin
         beat_q      <= '0;
         frame_cnt_q <= '0;
         tid_q       <= '0;
      end else if (accept) begin
         beat_q <= beat_last ? '0 : beat_q + LEN_W'(1);
         if (beat_last) begin
            frame_cnt_q <= cnt_inc;
            tid_q       <= (tid_q == CH_W'(NUM_CH - 1)) ? '0 : tid_q + CH_W'(1);
         end
      end
   end

   // Gap down-counter, loaded with the configured gap at each non-final frame end.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)                       gap_q <= '0;
      else if (frame_end && !run_over)  gap_q <= gap_cfg_q;
      else if (state_q == GAP)          gap_q <= gap_q - LEN_W'(1);
   end

   // Sticky stop request: armed during a run, cleared once the run ends.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)                                         stop_q <= 1'b0;
      else if (launch || state_q == DONE)                 stop_q <= 1'b0;
      else if ((state_q == SEND || state_q == GAP) && stop) stop_q <= 1'b1;
   end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomised + directed bench for axis_pattern_gen against a frame-level reference model.
module tb_axis_pattern_gen;

   localparam int DSIZE  = 16;
   localparam int LEN_W  = 16;
   localparam int NUM_CH = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, stop;
   logic [1:0]        cfg_mode;
   logic [DSIZE-1:0]  cfg_seed;
   logic [LEN_W-1:0]  cfg_frame_len, cfg_frame_num, cfg_gap;
   logic              busy, done;
   logic [LEN_W-1:0]  frame_cnt;

   axis_pattern_gen_if #(.DSIZE(DSIZE), .CH_W(2)) axis ();

   axis_pattern_gen #(.DSIZE(DSIZE), .LEN_W(LEN_W), .NUM_CH(NUM_CH)) dut (
      .clock(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_frame_len(cfg_frame_len),
      .cfg_frame_num(cfg_frame_num), .cfg_gap(cfg_gap), .out(axis),
      .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0, n_pass = 0;
   int cyc = 0, done_cyc = 0, acc_cnt = 0;
   int rdy_mode = 0;

   typedef struct {
      logic [15:0] data;
      logic        last, user;
      logic [1:0]  tid;
      int          cyc;
   } beat_t;
   beat_t log_q[$];

   // reference model state
   bit   m_run = 0, m_done_due = 0, m_stop = 0;
   int   m_gap_left = 0, m_k = 0, m_frames = 0;
   int   m_mode = 0, m_len = 1, m_num = 0, m_gap = 0;
   logic [15:0] m_seed = '0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
   endtask

   function automatic logic [15:0] prbs_word(input logic [15:0] seed, input int k);
      logic [14:0] s;
      s = (seed[14:0] == 15'd0) ? 15'd1 : seed[14:0];
      for (int i = 0; i < k; i++) s = {s[13:0], s[14] ^ s[13]};
      return {1'b0, s};
   endfunction

   function automatic logic [15:0] exp_data(input int k);
      case (m_mode)
         0:       return 16'(m_seed + 16'(k));
         1:       return prbs_word(m_seed, k);
         2:       return m_seed;
         default: return 16'(1) << (k % 16);
      endcase
   endfunction

   // per-cycle compare + model step
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tlast", axis.tlast, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            m_run = 0; m_done_due = 0; m_frames = 0; m_gap_left = 0;
            continue;
         end
         begin
            bit ev;
            int idx, fr;
            ev  = m_run && !m_done_due && (m_gap_left == 0);
            idx = m_k % m_len;
            fr  = m_k / m_len;
            chk("tvalid", axis.tvalid, ev);
            chk("done", done, m_done_due);
            chk("busy", busy, m_run && !m_done_due);
            chk("frame_cnt", frame_cnt, 16'(m_frames));
            if (ev && axis.tvalid) begin
               chk("tdata", axis.tdata, exp_data(m_k));
               chk("tlast", axis.tlast, idx == m_len - 1);
               chk("tuser", axis.tuser, idx == 0);
               chk("tid", axis.tid, fr % NUM_CH);
            end
            if (done) done_cyc = cyc;
            if (m_done_due) begin
               m_done_due = 0; m_run = 0;
            end else if (!m_run) begin
               if (start) begin
                  m_run = 1; m_stop = 0; m_k = 0; m_frames = 0; m_gap_left = 0;
                  m_mode = cfg_mode; m_seed = cfg_seed;
                  m_len = (cfg_frame_len == 0) ? 1 : int'(cfg_frame_len);
                  m_num = cfg_frame_num; m_gap = cfg_gap;
                  log_q.delete();
               end
            end else begin
               if (stop) m_stop = 1;
               if (m_gap_left > 0) begin
                  if (m_stop) m_done_due = 1;
                  else m_gap_left--;
               end else if (axis.tready) begin
                  log_q.push_back('{axis.tdata, axis.tlast, axis.tuser, axis.tid, cyc});
                  m_k++; acc_cnt++;
                  if (idx == m_len - 1) begin
                     m_frames++;
                     if ((m_num != 0 && m_frames == m_num) || m_stop) m_done_due = 1;
                     else m_gap_left = m_gap;
                  end
               end
            end
         end
      end
   end

   // tready policy: 0 always, 1 toggling, 2 random ~75%
   initial begin
      axis.tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       axis.tready = 1'b1;
            1:       axis.tready = ~axis.tready;
            default: axis.tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_run(input int md, input logic [15:0] sd, input int ln, input int nm, input int gp);
      cfg_mode = 2'(md); cfg_seed = sd;
      cfg_frame_len = 16'(ln); cfg_frame_num = 16'(nm); cfg_gap = 16'(gp);
      acc_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_mode = 2'($urandom); cfg_seed = 16'($urandom);
      cfg_frame_len = 16'($urandom_range(0, 9)); cfg_frame_num = 16'($urandom_range(0, 9));
      cfg_gap = 16'($urandom_range(0, 9));
   endtask

   task automatic wait_done(input int maxc, input int stop_at, input bit spur_start);
      bit seen = 0;
      for (int i = 0; i < maxc && !seen; i++) begin
         if (i == stop_at) stop = 1'b1;
         if (spur_start && i == 2) start = 1'b1;
         tick();
         stop = 1'b0; start = 1'b0;
         if (done) seen = 1;
      end
      chk("done_seen", seen, 1);
      tick();
   endtask

   initial begin
      int lc;
      rst_n = 1'b0; start = 0; stop = 0;
      cfg_mode = 0; cfg_seed = 0; cfg_frame_len = 0; cfg_frame_num = 0; cfg_gap = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // COUNT seed 0, len 4, num 2, gap 3, always ready
      rdy_mode = 0;
      start_run(0, 16'h0000, 4, 2, 3);
      wait_done(200, -1, 0);
      chk("t1_beats", log_q.size(), 8);
      if (log_q.size() == 8) begin
         chk("t1_first", log_q[0].data, 16'h0000);
         chk("t1_last_data", log_q[7].data, 16'h0007);
         chk("t1_tlast3", log_q[3].last, 1);
         chk("t1_tuser4", log_q[4].user, 1);
         chk("t1_gap_cycles", log_q[4].cyc - log_q[3].cyc, 4);
         chk("t1_done_lat", done_cyc - log_q[7].cyc, 1);
      end
      chk("t1_frame_cnt", frame_cnt, 2);

      // same config, toggling ready
      rdy_mode = 1;
      start_run(0, 16'h0000, 4, 2, 3);
      wait_done(200, -1, 0);
      chk("t2_beats", log_q.size(), 8);
      if (log_q.size() == 8) begin
         chk("t2_last_data", log_q[7].data, 16'h0007);
         chk("t2_done_lat", done_cyc - log_q[7].cyc, 1);
      end

      // PRBS15 seed 0, len 8, num 1
      rdy_mode = 0;
      start_run(1, 16'h0000, 8, 1, 0);
      wait_done(200, -1, 0);
      chk("t3_beats", log_q.size(), 8);
      lc = 0;
      foreach (log_q[i]) if (log_q[i].last) lc++;
      chk("t3_tlast_count", lc, 1);
      if (log_q.size() == 8) begin
         chk("t3_first", log_q[0].data, 16'h0001);
         chk("t3_second", log_q[1].data, 16'h0002);
      end

      // WALK1 len 5, num 4, gap 0
      start_run(3, 16'hABCD, 5, 4, 0);
      wait_done(200, -1, 0);
      chk("t4_beats", log_q.size(), 20);
      if (log_q.size() == 20) begin
         chk("t4_data4", log_q[4].data, 16'h0010);
         chk("t4_wrap", log_q[16].data, 16'h0001);
         chk("t4_tid1", log_q[5].tid, 1);
         chk("t4_tid2", log_q[10].tid, 2);
         chk("t4_tid3", log_q[15].tid, 0);
         chk("t4_no_bubble", log_q[5].cyc - log_q[4].cyc, 1);
      end

      // infinite run, stop during frame 1
      start_run(0, 16'd100, 6, 0, 2);
      for (int i = 0; i < 200 && acc_cnt < 8; i++) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      wait_done(200, -1, 0);
      chk("t5_frame_cnt", frame_cnt, 2);
      chk("t5_beats", log_q.size(), 12);
      if (log_q.size() == 12) chk("t5_tlast", log_q[11].last, 1);

      // reset mid-frame
      start_run(0, 16'h0050, 6, 3, 1);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1 chk("t6_async_tvalid", axis.tvalid, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      start_run(0, 16'h0050, 3, 1, 0);
      wait_done(200, -1, 0);
      if (log_q.size() > 0) begin
         chk("t6_restart_data", log_q[0].data, 16'h0050);
         chk("t6_restart_tid", log_q[0].tid, 0);
      end

      // randomised runs
      rdy_mode = 2;
      for (int r = 0; r < 16; r++) begin
         int nm, sa;
         if (r % 2 == 1) begin stop = 1'b1; tick(); stop = 1'b0; end
         nm = $urandom_range(0, 4);
         sa = (nm == 0 || $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
         start_run($urandom_range(0, 3), 16'($urandom), $urandom_range(0, 6), nm,
                   $urandom_range(0, 3));
         wait_done(3000, sa, r % 3 == 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
